// File: rtl/extio8x4_axis_rr_arbiter.sv
// Round-robin arbiter sharing one 8-bit AXIS RX channel of the extio8x4 initiator
// between NUM_SRC byte-stream requesters. Each grant lasts up to BURST_MAX bytes.
// A single output register drives the initiator, and m_tsrc tags each byte with its source.
// Optional transfer counter: define EXTIO8X4_ARB_STATS_EN.
module extio8x4_axis_rr_arbiter #(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_SRC-1:0]   s_tvalid,
    output logic [NUM_SRC-1:0]   s_tready,
    input  logic [8*NUM_SRC-1:0] s_tdata8,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [7:0]           m_tdata8,
    output logic [2:0]           m_tsrc,
    output logic                 grant_active,
    input  logic                 stat_clear,
    output logic [CNT_W-1:0]     stat_xfer_cnt
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    localparam logic [2:0] LAST_SRC  = 3'(NUM_SRC - 1);
    localparam logic [7:0] LAST_BEAT = 8'(BURST_MAX - 1);

    logic [0:0] state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] grant_q, grant_d;
    logic [7:0] burst_q, burst_d;
    logic [2:0] pick;

    // Inputs widened to the full 8-source range so a 3-bit index is always in bounds.
    logic [7:0]  valid_pad;
    logic [63:0] data_pad;
    logic        src_ready;
    logic        src_xfer;
    logic [2:0]  grant_next_src;

    assign valid_pad = 8'(s_tvalid);
    assign data_pad  = 64'(s_tdata8);

    // Output register can accept when empty or draining this cycle.
    assign src_ready      = (state_q == StGrant) && (!m_tvalid || m_tready);
    assign src_xfer       = src_ready && valid_pad[grant_q];
    assign grant_active   = (state_q == StGrant);
    assign grant_next_src = (grant_q == LAST_SRC) ? 3'd0 : grant_q + 3'd1;

    function automatic logic [2:0] wrap_idx(input int v);
        if (v >= int'(NUM_SRC)) begin
            return 3'(v - int'(NUM_SRC));
        end
        return 3'(v);
    endfunction

    // First requester at or after ptr; scanned backwards so the nearest one wins.
    always_comb begin
        pick = ptr_q;
        for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
            if (valid_pad[wrap_idx(int'(ptr_q) + k)]) begin
                pick = wrap_idx(int'(ptr_q) + k);
            end
        end
    end

    // Only the granted source sees ready.
    always_comb begin
        s_tready = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (src_ready && (grant_q == 3'(i))) begin
                s_tready[i] = 1'b1;
            end
        end
    end

    // Arbitration FSM next state: grant on request, release on burst end or idle source.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        burst_d = burst_q;
        case (state_q)
            StIdle: begin
                if (|s_tvalid) begin
                    grant_d = pick;
                    burst_d = 8'd0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (src_xfer) begin
                    burst_d = burst_q + 8'd1;
                    if (burst_q == LAST_BEAT) begin
                        state_d = StIdle;
                        ptr_d   = grant_next_src;
                    end
                end else if (src_ready) begin
                    // Ready offered but the source had nothing: give up the grant.
                    state_d = StIdle;
                    ptr_d   = grant_next_src;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            ptr_q   <= 3'd0;
            grant_q <= 3'd0;
            burst_q <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
        end
    end

    // Output register: load on source transfer, empty on drain with no refill.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_tvalid <= 1'b0;
            m_tdata8 <= 8'd0;
            m_tsrc   <= 3'd0;
        end else if (src_xfer) begin
            m_tvalid <= 1'b1;
            m_tdata8 <= data_pad[{grant_q, 3'b000} +: 8];
            m_tsrc   <= grant_q;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

`ifdef EXTIO8X4_ARB_STATS_EN
    // Saturating count of m-side handshakes; clear beats increment.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_xfer_cnt <= '0;
        end else if (stat_clear) begin
            stat_xfer_cnt <= '0;
        end else if (m_tvalid && m_tready && (stat_xfer_cnt != '1)) begin
            stat_xfer_cnt <= stat_xfer_cnt + 1'b1;
        end
    end
`else
    logic unused_stat_clear;
    assign unused_stat_clear = stat_clear;
    assign stat_xfer_cnt     = '0;
`endif

endmodule
